rvsteel_spi_sequencer: RTL
==========================

# rvsteel_spi_sequencer

Bus-master controller that runs complete multi-byte SPI transactions on the `rvsteel_spi` peripheral through that peripheral's memory-mapped IO interface, so a host or DMA engine does not poll it byte by byte.

- Accepts one command: mode, clock divider, chip select and byte count.
- Programs the peripheral's registers, streams TX bytes in and RX bytes out over valid/ready.
- Releases chip select at the end.
- Sits between a streaming client and the slave port of `rvsteel_spi`.

## Interface
Parameters:
- `SPI_BASE_ADDRESS`, 32'h90000000, base of the controlled peripheral. Register offsets:
  - CPOL +0x00, CPHA +0x04, CS +0x08, DIV +0x0C
  - TX +0x10, RX +0x14, STATUS +0x18

Ports:
- `clock` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake.
- `cmd_cpol` in 1, `cmd_cpha` in 1: SPI mode.
- `cmd_div` in 8: value for DIV.
- `cmd_cs` in 8: chip-select index.
- `cmd_len` in 8: number of bytes minus 1 (1–256 bytes).
- `tx_data` in 8, `tx_valid` in 1, `tx_ready` out 1: outgoing bytes.
- `rx_data` out 8, `rx_valid` out 1, `rx_ready` in 1: received bytes.
- `busy` out 1: transaction in progress.
- `done` out 1: one-cycle pulse at normal completion.
- `error` out 1: one-cycle pulse on a rejected command.
- `rw_address` out 32, `write_data` out 32, `write_strobe` out 4, `write_request` out 1, `write_response` in 1.
- `read_request` out 1, `read_data` in 32, `read_response` in 1.

## Operation
- FSM states: IDLE, CFG_CPOL, CFG_CPHA, CFG_DIV, CFG_CS, GET_TX, WR_TX, POLL_BUSY, POLL_DONE, RD_RX, PUSH_RX, RELEASE, FINISH.
- Every bus state has an ISSUE phase and a WAIT phase.
  - ISSUE: the request is high for exactly one cycle. Writes use `write_strobe`=4'hF; `write_data` is zero-extended.
  - WAIT: request low until the matching response arrives.
- IDLE: `cmd_ready`=1. On `cmd_valid`:
  - If `cmd_cs`=8'hFF: pulse `error`, stay in IDLE, issue no bus traffic.
  - Otherwise: latch the fields, set the byte counter to `cmd_len`, assert `busy`, go to CFG_CPOL.
- Configuration: CFG_CPOL, CFG_CPHA, CFG_DIV and CFG_CS write their registers in that order.
- GET_TX: `tx_ready`=1. On `tx_valid`, latch the byte and go to WR_TX, which writes TX.
- POLL_BUSY: read STATUS until bit0=1.
- POLL_DONE: read STATUS until bit0=0.
- RD_RX: read RX and capture `read_data[7:0]` on `read_response`.
- PUSH_RX: `rx_valid`=1 with `rx_data` held until `rx_ready`.
  - Counter 0: go to RELEASE.
  - Otherwise: decrement and go to GET_TX.
- RELEASE: write CS=8'hFF. FINISH: pulse `done`, deassert `busy`, go to IDLE.
- Backpressure on `tx_valid` or `rx_ready` stalls the FSM. Chip select stays asserted and the SPI clock stays idle, so no data is lost.
- Byte counter is 8 bits and never wraps: the transaction ends when the counter is 0 in PUSH_RX.

## Timing
- Reset values:
  - All outputs 0: `cmd_ready`, `busy`, `done`, `error`, `tx_ready`, `rx_valid`, `rx_data`, `rw_address`, `write_data`, `write_strobe`, and both requests.
  - FSM returns to IDLE. `cmd_ready` rises in the first cycle after reset deasserts.
- Bus access: request in cycle N. Response expected at N+1. Next request no earlier than N+2.
- `read_data` is sampled in the cycle `read_response`=1.
- Configuration takes 8 cycles from command acceptance to the first `tx_ready`.
- Per-byte bus overhead outside the SPI shift time is 8 cycles minimum: TX write 2, polls 2 each, RX read 2.
- POLL_BUSY is required because STATUS stays 0 for up to 2 cycles after the TX write.
- `done`, `error` and `cmd_ready` are never high in the same cycle as `busy`=0→1 for another command.
- Reset mid-transaction aborts immediately: no RELEASE write is issued. The peripheral must share the same reset.

## Configuration
- Macro `RVSTEEL_SPI_SEQ_CS_HOLD_EN`.
- Defined: adds input `cmd_hold` (1), latched with the command. When `cmd_hold`=1, RELEASE is skipped (PUSH_RX goes straight to FINISH), so chip select stays asserted for a chained command.
- Undefined: port absent; RELEASE always executes.

## Test plan
- Single byte: cs=0, mode 0, div=0, tx 0xA5, peripheral `poci` looped to `pico`.
  - Write sequence: CPOL=0, CPHA=0, DIV=0, CS=0, TX=0xA5, then CS=0xFF.
  - `rx_data`=0xA5, one `done` pulse.
- 3-byte burst (`cmd_len`=2), mode 3, div=4, tx 0x01/0x80/0xFF, `rx_ready` low for 10 cycles on byte 2.
  - Three RX bytes equal to TX, in order.
  - CS stays 0 until the final release.
- `cmd_cs`=0xFF: `error` pulses once, no request asserted, `busy` stays 0.
- `tx_valid` withheld for 20 cycles before byte 1: no TX write during the gap, then normal completion.
- Reset asserted during POLL_DONE: all outputs 0 asynchronously; after release, a new command completes normally.
- With `RVSTEEL_SPI_SEQ_CS_HOLD_EN` and `cmd_hold`=1: no CS=0xFF write and `done` pulses. A following command with hold=0 ends with CS=0xFF.

Source files
------------

// File: rtl/rvsteel_spi_sequencer.sv
// rvsteel_spi_sequencer: runs whole multi-byte SPI transactions on rvsteel_spi
// over its memory-mapped slave port (CPOL/CPHA/DIV/CS config, TX/RX streaming).
// Ports: clock/reset, cmd_* command handshake, tx_*/rx_* byte streams,
// busy/done/error status, rw_address/write_*/read_* bus master side.
// Optional: `RVSTEEL_SPI_SEQ_CS_HOLD_EN adds cmd_hold (skip CS release).
`timescale 1ns/1ps
module rvsteel_spi_sequencer #(
  parameter logic [31:0] SPI_BASE_ADDRESS = 32'h90000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_cpol,
  input  logic        cmd_cpha,
  input  logic [7:0]  cmd_div,
  input  logic [7:0]  cmd_cs,
  input  logic [7:0]  cmd_len,
`ifdef RVSTEEL_SPI_SEQ_CS_HOLD_EN
  input  logic        cmd_hold,
`endif
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] rw_address,
  output logic [31:0] write_data,
  output logic [3:0]  write_strobe,
  output logic        write_request,
  input  logic        write_response,
  output logic        read_request,
  input  logic [31:0] read_data,
  input  logic        read_response
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_CFG_CPOL  = 4'd1;
  localparam logic [3:0] S_CFG_CPHA  = 4'd2;
  localparam logic [3:0] S_CFG_DIV   = 4'd3;
  localparam logic [3:0] S_CFG_CS    = 4'd4;
  localparam logic [3:0] S_GET_TX    = 4'd5;
  localparam logic [3:0] S_WR_TX     = 4'd6;
  localparam logic [3:0] S_POLL_BUSY = 4'd7;
  localparam logic [3:0] S_POLL_DONE = 4'd8;
  localparam logic [3:0] S_RD_RX     = 4'd9;
  localparam logic [3:0] S_PUSH_RX   = 4'd10;
  localparam logic [3:0] S_RELEASE   = 4'd11;
  localparam logic [3:0] S_FINISH    = 4'd12;

  localparam logic [4:0] OFF_CPOL   = 5'h00;
  localparam logic [4:0] OFF_CPHA   = 5'h04;
  localparam logic [4:0] OFF_CS     = 5'h08;
  localparam logic [4:0] OFF_DIV    = 5'h0C;
  localparam logic [4:0] OFF_TX     = 5'h10;
  localparam logic [4:0] OFF_RX     = 5'h14;
  localparam logic [4:0] OFF_STATUS = 5'h18;

  logic [3:0] r_state;
  // 0 = ISSUE (request high one cycle), 1 = WAIT (for response)
  logic       r_phase;
  // keeps cmd_ready low until the first cycle after reset release
  logic       r_live;
  logic       r_cpol;
  logic       r_cpha;
  logic [7:0] r_div;
  logic [7:0] r_cs;
  logic [7:0] r_cnt;
  logic [7:0] r_tx;
  logic [7:0] r_rx;
  logic       r_error;

  logic       w_is_wr;
  logic       w_is_rd;
  logic       w_bus;
  logic       w_resp;
  logic [4:0] w_off;
  logic [7:0] w_wdat;
  logic [3:0] w_next;
  logic       w_hold;
  logic       w_unused_rd;

`ifdef RVSTEEL_SPI_SEQ_CS_HOLD_EN
  logic r_hold;
  assign w_hold = r_hold;
`else
  assign w_hold = 1'b0;
`endif

  always_comb begin
    w_is_wr = 1'b0;
    w_is_rd = 1'b0;
    w_off   = 5'h00;
    w_wdat  = 8'h00;
    w_next  = S_IDLE;
    case (r_state)
      S_CFG_CPOL: begin
        w_is_wr = 1'b1;
        w_off   = OFF_CPOL;
        w_wdat  = {7'b0, r_cpol};
        w_next  = S_CFG_CPHA;
      end
      S_CFG_CPHA: begin
        w_is_wr = 1'b1;
        w_off   = OFF_CPHA;
        w_wdat  = {7'b0, r_cpha};
        w_next  = S_CFG_DIV;
      end
      S_CFG_DIV: begin
        w_is_wr = 1'b1;
        w_off   = OFF_DIV;
        w_wdat  = r_div;
        w_next  = S_CFG_CS;
      end
      S_CFG_CS: begin
        w_is_wr = 1'b1;
        w_off   = OFF_CS;
        w_wdat  = r_cs;
        w_next  = S_GET_TX;
      end
      S_WR_TX: begin
        w_is_wr = 1'b1;
        w_off   = OFF_TX;
        w_wdat  = r_tx;
        w_next  = S_POLL_BUSY;
      end
      // STATUS lags the TX write, so first wait for busy to show up
      S_POLL_BUSY: begin
        w_is_rd = 1'b1;
        w_off   = OFF_STATUS;
        w_next  = read_data[0] ? S_POLL_DONE : S_POLL_BUSY;
      end
      S_POLL_DONE: begin
        w_is_rd = 1'b1;
        w_off   = OFF_STATUS;
        w_next  = read_data[0] ? S_POLL_DONE : S_RD_RX;
      end
      S_RD_RX: begin
        w_is_rd = 1'b1;
        w_off   = OFF_RX;
        w_next  = S_PUSH_RX;
      end
      S_RELEASE: begin
        w_is_wr = 1'b1;
        w_off   = OFF_CS;
        w_wdat  = 8'hFF;
        w_next  = S_FINISH;
      end
      default: ;
    endcase
  end

  assign w_bus  = w_is_wr | w_is_rd;
  assign w_resp = (w_is_wr & write_response) |
                  (w_is_rd & read_response);
  assign w_unused_rd = ^read_data[31:8];

  assign write_request = w_is_wr & ~r_phase;
  assign read_request  = w_is_rd & ~r_phase;
  assign write_strobe  = write_request ? 4'hF : 4'h0;
  assign write_data    = {24'b0, w_wdat};
  assign rw_address    = w_bus ?
    SPI_BASE_ADDRESS + {27'b0, w_off} : 32'h0;

  assign cmd_ready = r_live & (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE) &
                     (r_state != S_FINISH);
  assign done      = (r_state == S_FINISH);
  assign error     = r_error;
  assign tx_ready  = (r_state == S_GET_TX);
  assign rx_valid  = (r_state == S_PUSH_RX);
  assign rx_data   = r_rx;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_phase <= 1'b0;
      r_live  <= 1'b0;
      r_cpol  <= 1'b0;
      r_cpha  <= 1'b0;
      r_div   <= 8'h00;
      r_cs    <= 8'h00;
      r_cnt   <= 8'h00;
      r_tx    <= 8'h00;
      r_rx    <= 8'h00;
      r_error <= 1'b0;
`ifdef RVSTEEL_SPI_SEQ_CS_HOLD_EN
      r_hold  <= 1'b0;
`endif
    end else begin
      r_live  <= 1'b1;
      r_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_live && cmd_valid) begin
            // CS index 0xFF would mean "deselect": reject without bus traffic
            if (cmd_cs == 8'hFF) begin
              r_error <= 1'b1;
            end else begin
              r_cpol  <= cmd_cpol;
              r_cpha  <= cmd_cpha;
              r_div   <= cmd_div;
              r_cs    <= cmd_cs;
              r_cnt   <= cmd_len;
`ifdef RVSTEEL_SPI_SEQ_CS_HOLD_EN
              r_hold  <= cmd_hold;
`endif
              r_phase <= 1'b0;
              r_state <= S_CFG_CPOL;
            end
          end
        end
        S_GET_TX: begin
          if (tx_valid) begin
            r_tx    <= tx_data;
            r_phase <= 1'b0;
            r_state <= S_WR_TX;
          end
        end
        S_PUSH_RX: begin
          if (rx_ready) begin
            if (r_cnt == 8'h00) begin
              r_state <= w_hold ? S_FINISH : S_RELEASE;
            end else begin
              r_cnt   <= r_cnt - 8'd1;
              r_state <= S_GET_TX;
            end
            r_phase <= 1'b0;
          end
        end
        S_FINISH: begin
          r_state <= S_IDLE;
        end
        default: begin
          if (w_bus) begin
            if (!r_phase) begin
              r_phase <= 1'b1;
            end else if (w_resp) begin
              r_phase <= 1'b0;
              r_state <= w_next;
              if (r_state == S_RD_RX)
                r_rx <= read_data[7:0];
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule
